// File: rtl/rv_ui_pkg.sv
// Shared types and default timing for the push-button conditioning path.
package rv_ui_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE       = 2'd0,
        BTN_HOLD_DELAY = 2'd1,
        BTN_REPEATING  = 2'd2
    } btn_state_t;

    // Without auto-repeat the hold-delay state is the only held state.
    localparam btn_state_t BTN_HELD = BTN_HOLD_DELAY;

    localparam int BTN_DEFAULT_DEBOUNCE = 50000;    // 10 ms at 5 MHz
    localparam int BTN_DEFAULT_DELAY    = 2500000;  // 500 ms
    localparam int BTN_DEFAULT_PERIOD   = 500000;   // 100 ms

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button inputs and conditioned level/pulse outputs of btn_conditioner.
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    modport master (output btn_raw, input btn_level, btn_press, btn_release, any_press);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release, any_press);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, counter debounce, press/release pulses.
// Auto-repeat of the press pulse is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import rv_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEFAULT_DEBOUNCE
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = BTN_DEFAULT_DELAY,
    parameter int REPEAT_PERIOD = BTN_DEFAULT_PERIOD
`endif
) (
    input  logic clk_5M,
    input  logic Rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls,
    output logic press_d
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    btn_state_t    state;
    logic          accept, acc_press, rls_d;

    assign accept    = (s2 != level) && (cnt == CNT_MAX);
    assign acc_press = accept && (state == BTN_IDLE);
    assign rls_d     = accept && (state != BTN_IDLE);

`ifdef BTN_AUTOREPEAT_EN
    // Sized for the larger interval so a long period cannot overflow the counter.
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rep_fire;

    // An accepted release wins over a repeat falling on the same edge.
    always_comb begin
        rep_fire = 1'b0;
        if (!accept) begin
            case (state)
                BTN_HOLD_DELAY: rep_fire = (rcnt == DLY_MAX);
                BTN_REPEATING:  rep_fire = (rcnt == PER_MAX);
                default:        rep_fire = 1'b0;
            endcase
        end
    end

    assign press_d = acc_press | rep_fire;

    always_ff @(posedge clk_5M) begin
        if (Rst) begin
            state <= BTN_IDLE;
            rcnt  <= '0;
        end else if (rls_d) begin
            state <= BTN_IDLE;
            rcnt  <= '0;
        end else if (acc_press) begin
            state <= BTN_HOLD_DELAY;
            rcnt  <= '0;
        end else begin
            case (state)
                BTN_HOLD_DELAY: begin
                    if (rep_fire) begin
                        state <= BTN_REPEATING;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                BTN_REPEATING: rcnt <= rep_fire ? '0 : rcnt + 1'b1;
                default:       rcnt <= '0;
            endcase
        end
    end
`else
    assign press_d = acc_press;

    always_ff @(posedge clk_5M) begin
        if (Rst)            state <= BTN_IDLE;
        else if (acc_press) state <= BTN_HELD;
        else if (rls_d)     state <= BTN_IDLE;
    end
`endif

    always_ff @(posedge clk_5M) begin
        if (Rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= press_d;
            rls   <= rls_d;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounced button channels plus a registered any_press.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module btn_conditioner
    import rv_ui_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = BTN_DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = BTN_DEFAULT_DELAY,
    parameter int REPEAT_PERIOD   = BTN_DEFAULT_PERIOD
) (
    input logic               clk_5M,
    input logic               Rst,
    btn_conditioner_if.slave  bus
);
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
        $error("btn_conditioner: timing parameters must be >= 2");
    end

    logic [N_BTN-1:0] level, press, rls, press_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_5M  (clk_5M),
            .Rst     (Rst),
            .raw     (bus.btn_raw[i]),
            .level   (level[i]),
            .press   (press[i]),
            .rls     (rls[i]),
            .press_d (press_d[i])
        );
    end

    // Built from the channels' next-press values so it lines up with btn_press.
    always_ff @(posedge clk_5M) begin
        if (Rst) bus.any_press <= 1'b0;
        else     bus.any_press <= |press_d;
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rls;
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk_5M = 1'b0;
    logic Rst    = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic [4:0] el, ep, er;

    btn_conditioner_if #(.N_BTN(5)) bus ();

    btn_conditioner #(
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk_5M (clk_5M),
        .Rst    (Rst),
        .bus    (bus)
    );

    always #100 clk_5M = ~clk_5M;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d {lvl,prs,rel,any} got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // Advance one edge, then compare all outputs against the expected vectors.
    task automatic step_chk(input string tag, input logic [4:0] lvl, input logic [4:0] prs,
                            input logic [4:0] rel);
        @(posedge clk_5M);
        #1;
        cyc++;
        chk(tag, {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press},
            {lvl, prs, rel, |prs});
    endtask

    initial begin
        bus.btn_raw = 5'h1F;

        // Buttons held through reset
        for (int i = 0; i < 3; i++) step_chk("in_reset", '0, '0, '0);
        Rst = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            if (e == 7) bus.btn_raw = '0;
            el = (e >= 5 && e < 12) ? 5'h1F : 5'h00;
            ep = (e == 5)  ? 5'h1F : 5'h00;
            er = (e == 12) ? 5'h1F : 5'h00;
            step_chk("post_reset", el, ep, er);
        end

        // Clean press/release on channel 0, raw high for 30 cycles
        for (int e = 0; e <= 44; e++) begin
            bus.btn_raw[0] = (e < 30);
            el = '0; ep = '0; er = '0;
            el[0] = (e >= 5 && e < 35);
            ep[0] = (e == 5) || (AR && (e == 25 || e == 33));
            er[0] = (e == 35);
            step_chk("clean", el, ep, er);
        end

        // Bounce on channel 2: 1,0,1,0,1 then steady high, released at edge 15
        for (int e = 0; e <= 22; e++) begin
            bus.btn_raw[2] = (e < 5) ? (e % 2 == 0) : (e < 15);
            el = '0; ep = '0; er = '0;
            el[2] = (e >= 9 && e < 20);
            ep[2] = (e == 9);
            er[2] = (e == 20);
            step_chk("bounce", el, ep, er);
        end

        // Glitch on channel 3, one cycle short of the debounce window
        for (int e = 0; e <= 10; e++) begin
            bus.btn_raw[3] = (e < 3);
            step_chk("glitch", '0, '0, '0);
        end

        // Long hold on channel 1; the release lands on a would-be repeat edge
        for (int e = 0; e <= 72; e++) begin
            bus.btn_raw[1] = (e < 60);
            el = '0; ep = '0; er = '0;
            el[1] = (e >= 5 && e < 65);
            ep[1] = (e == 5) ||
                    (AR && (e == 25 || e == 33 || e == 41 || e == 49 || e == 57));
            er[1] = (e == 65);
            step_chk("repeat", el, ep, er);
        end

        // Channels 0 and 4 rise together; channel 4 drops after 2 cycles
        for (int e = 0; e <= 18; e++) begin
            bus.btn_raw[0] = (e < 10);
            bus.btn_raw[4] = (e < 2);
            el = '0; ep = '0; er = '0;
            el[0] = (e >= 5 && e < 15);
            ep[0] = (e == 5);
            er[0] = (e == 15);
            step_chk("indep", el, ep, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
